// File: rtl/auto_bcd_counter_nd.sv
// Purpose: free-running multi-digit BCD counter with prescaler, modulus, up/down, pause, clear key and 7-seg decode.
// Latency: bcd/wrap update one cycle after a tick; segments are combinational from bcd; clear lands 3 edges after KEY_2 falls.
// Backpressure: none; SW16 = 0 pauses the prescaler and the count, otherwise the counter always advances.
//
// Ports:
//   PIN_Y2   clock, rising edge
//   KEY_3    async active-low reset
//   KEY_2    active-low clear key (asynchronous, synchronised internally)
//   SW17     direction, 0 = up, 1 = down
//   SW16     run enable, 1 = count, 0 = pause
//   bcd      count, digit k at [4k+3:4k], digit 0 least significant
//   wrap     one-cycle pulse after a wrapping step
//   segments active-low a..g per digit, digit k at [7k+6:7k], bit 7k = a
module auto_bcd_counter_nd #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 50000000,
    parameter int MAX_COUNT = 9999,
    parameter int BLANK_LZ  = 0
) (
    input  logic                  PIN_Y2,
    input  logic                  KEY_3,
    input  logic                  KEY_2,
    input  logic                  SW17,
    input  logic                  SW16,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    // Decimal modulus -> packed BCD, evaluated at elaboration.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("auto_bcd_counter_nd: DIGITS must be 1..8");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("auto_bcd_counter_nd: PRESCALE must be >= 1");
        end
        if (MAX_COUNT < 0 || MAX_COUNT > 10**DIGITS - 1) begin : g_bad_max
            $error("auto_bcd_counter_nd: MAX_COUNT does not fit in DIGITS decimal digits");
        end
    endgenerate

    // Ripple increment: a digit at 9 rolls to 0 and carries into the next one.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement: a digit at 0 rolls to 9 and borrows from the next one.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Clear key: two flops for metastability, a third to find the falling edge
    // of the synchronised level so a held key produces a single clear.
    logic key_s1;
    logic key_s2;
    logic key_s3;
    logic clr;

    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_s3 <= 1'b1;
        end else begin
            key_s1 <= KEY_2;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign clr = key_s3 & ~key_s2;

    // Prescaler holds while paused so a resumed period completes, not restarts.
    logic [PW-1:0] pres;
    logic          tick;

    assign tick = SW16 && (pres == PRE_LAST);

    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3) begin
            pres <= '0;
        end else if (clr) begin
            pres <= '0;
        end else if (SW16) begin
            pres <= tick ? '0 : pres + PW'(1);
        end
    end

    // Counter; clear wins over a coincident tick and never raises wrap.
    always_ff @(posedge PIN_Y2 or negedge KEY_3) begin
        if (!KEY_3) begin
            bcd  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            bcd  <= '0;
            wrap <= 1'b0;
        end else if (tick) begin
            if (!SW17) begin
                if (bcd == MAX_BCD) begin
                    bcd  <= '0;
                    wrap <= 1'b1;
                end else begin
                    bcd  <= bcd_inc(bcd);
                    wrap <= 1'b0;
                end
            end else begin
                if (bcd == '0) begin
                    bcd  <= MAX_BCD;
                    wrap <= 1'b1;
                end else begin
                    bcd  <= bcd_dec(bcd);
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // upper_nz[k]: some digit at position k or above is non-zero.
    logic [DIGITS-1:0] upper_nz;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign upper_nz[k] = |bcd[4*DIGITS-1:4*k];
            if (k == 0) begin : g_lsd
                assign segments[6:0] = seg7(bcd[3:0]);
            end else begin : g_upper
                assign segments[7*k +: 7] = ((BLANK_LZ != 0) && !upper_nz[k])
                                            ? 7'b1111111
                                            : seg7(bcd[4*k +: 4]);
            end
        end
    endgenerate

endmodule
